// File: rtl/cc1200_spi_pkg.sv
// Shared definitions for the CC1200-style SPI responder: header layout,
// strobe address range, FSM states and status-byte format.
package cc1200_spi_pkg;

  localparam int HDR_RW    = 7;
  localparam int HDR_BURST = 6;
  localparam int ADDR_W    = 6;

  localparam logic [ADDR_W-1:0] STROBE_BASE = 6'h30;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA,
    STROBE
  } state_e;

  typedef struct packed {
    logic       rsvd;
    logic [2:0] state;
    logic [3:0] zero;
  } status_t;

  function automatic logic [7:0] status_byte(input logic [2:0] chip_state);
    status_t s;
    s.rsvd  = 1'b0;
    s.state = chip_state;
    s.zero  = 4'b0000;
    return s;
  endfunction

endpackage

// File: rtl/cc1200_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, plus rise/fall
// detection on the synchronized level.
module cc1200_sync_edge #(
  parameter int   STAGES = 2,
  parameter logic INIT   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chain <= {STAGES{INIT}};
      prev  <= INIT;
    end else begin
      chain[0] <= d;
      for (int i = 1; i < STAGES; i++) chain[i] <= chain[i-1];
      prev <= chain[STAGES-1];
    end
  end

  assign q    = chain[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/cc1200_spi_responder.sv
// SPI mode-0 responder emulating the CC1200 register/strobe interface,
// fully oversampled on the system clock.
module cc1200_spi_responder
  import cc1200_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 48
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  output logic        miso,
  output logic        miso_oe,
  input  logic [2:0]  chip_state,
  output logic        wr_valid,
  output logic [5:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        strobe_valid,
  output logic [5:0]  strobe_addr
);

  localparam logic [ADDR_W-1:0] LAST_REG = ADDR_W'(NUM_REGS - 1);

  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_s, mosi_rise, mosi_fall;
  logic cs_q, cs_rise, cs_fall;
  logic sync_unused;

  cc1200_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  cc1200_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
  cc1200_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall));

  assign sync_unused = ^{sclk_q, mosi_rise, mosi_fall, cs_q};

  state_e            state;
  logic [2:0]        bit_cnt;
  logic [6:0]        rx;
  logic [7:0]        tx;
  logic              rw, burst, done;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        regs [NUM_REGS];

  logic [7:0]        byte_in;
  logic              in_range;
  logic [7:0]        rd_data;
  logic [ADDR_W-1:0] ptr_next;

  assign byte_in  = {rx, mosi_s};
  assign in_range = (ptr <= LAST_REG);
  assign rd_data  = in_range ? regs[ptr] : 8'h00;
  assign ptr_next = (ptr == LAST_REG) ? '0 : ptr + 6'd1;
  assign miso     = tx[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      rx           <= '0;
      tx           <= '0;
      rw           <= 1'b0;
      burst        <= 1'b0;
      done         <= 1'b0;
      ptr          <= '0;
      miso_oe      <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      strobe_valid <= 1'b0;
      strobe_addr  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_valid     <= 1'b0;
      strobe_valid <= 1'b0;
      // Deselect wins over everything; a partial byte is simply dropped.
      if (state != IDLE && cs_rise) begin
        state   <= IDLE;
        miso_oe <= 1'b0;
        tx      <= '0;
        rx      <= '0;
        bit_cnt <= '0;
      end else begin
        case (state)
          IDLE: if (cs_fall) begin
            tx      <= status_byte(chip_state);
            miso_oe <= 1'b1;
            bit_cnt <= '0;
            rx      <= '0;
            done    <= 1'b0;
            state   <= HDR;
          end
          HDR: begin
            if (sclk_rise) begin
              rx      <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rw    <= byte_in[HDR_RW];
                burst <= byte_in[HDR_BURST];
                ptr   <= byte_in[ADDR_W-1:0];
                if (byte_in[ADDR_W-1:0] >= STROBE_BASE) begin
                  strobe_valid <= 1'b1;
                  strobe_addr  <= byte_in[ADDR_W-1:0];
                  tx           <= '0;
                  state        <= STROBE;
                end else begin
                  state <= DATA;
                end
              end
            end else if (sclk_fall && bit_cnt != 3'd0) begin
              tx <= {tx[6:0], 1'b0};
            end
          end
          DATA: begin
            if (sclk_rise) begin
              rx      <= byte_in[6:0];
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7 && !done) begin
                if (!rw && in_range) begin
                  regs[ptr] <= byte_in;
                  wr_valid  <= 1'b1;
                  wr_addr   <= ptr;
                  wr_data   <= byte_in;
                end
                if (burst) ptr  <= ptr_next;
                else       done <= 1'b1;
              end
            end else if (sclk_fall) begin
              // The 8th fall (count wrapped to 0) preloads the next byte.
              if (bit_cnt != 3'd0) tx <= {tx[6:0], 1'b0};
              else if (done)       tx <= '0;
              else if (rw)         tx <= rd_data;
              else                 tx <= status_byte(chip_state);
            end
          end
          STROBE: tx <= '0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/cc1200_spi_responder.md
CC1200_SPI_RESPONDER -- requirements
Module: cc1200_spi_responder

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchronizer flops on sclk, mosi and cs_n.
REQ-002 SHALL have parameter NUM_REGS, default 48, the register file depth, addressed 0x00..NUM_REGS-1.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock, which must run at least 8x the SCLK frequency.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port sclk, input, 1 bit: SPI clock from the master, mode 0.
REQ-006 SHALL have port mosi, input, 1 bit: master-out data, MSB first.
REQ-007 SHALL have port cs_n, input, 1 bit: active-low chip select.
REQ-008 SHALL have port miso, output, 1 bit: responder-out data.
REQ-009 SHALL have port miso_oe, output, 1 bit: high while selected; the top level drives miso only when miso_oe is high, else Z.
REQ-010 SHALL have port chip_state, input, 3 bits: radio state reported in the status byte.
REQ-011 SHALL have port wr_valid, output, 1 bit: one-cycle pulse on each committed register write.
REQ-012 SHALL have port wr_addr, output, 6 bits, and port wr_data, output, 8 bits: address and data of the committed write.
REQ-013 SHALL have port strobe_valid, output, 1 bit: one-cycle pulse when a command strobe is received.
REQ-014 SHALL have port strobe_addr, output, 6 bits: the strobe address (0x30..0x3F).

Function
REQ-015 SHALL synchronize sclk, mosi and cs_n through SYNC_STAGES flops, then detect rising and falling edges of the synchronized sclk and cs_n.
REQ-016 SHALL implement the FSM IDLE -> HDR -> DATA or STROBE, leaving any state for IDLE on synchronized cs_n rising.
REQ-017 SHALL, in IDLE on cs_n falling, load the status byte {1'b0, chip_state, 4'b0000} into the TX shift register, assert miso_oe, and enter HDR.
REQ-018 SHALL sample mosi on each synchronized sclk rise, and shift TX on each synchronized sclk fall other than the 8th of a byte.
REQ-019 SHALL drive miso from TX bit 7.
REQ-020 SHALL decode the header after the 8th rise: bit7 = R/W (1 = read), bit6 = burst, bits5:0 = addr.
REQ-021 SHALL treat addr >= 0x30 as a strobe: pulse strobe_valid with strobe_addr = addr one cycle after the 8th rise, then enter STROBE.
REQ-022 SHALL, in STROBE, ignore all further bits and drive miso 0.
REQ-023 SHALL, for addr < 0x30, enter DATA with the current pointer = addr.
REQ-024 SHALL, for a read, load reg[pointer] into TX on the 8th sclk fall of the preceding byte, so its MSB is valid before the next rise.
REQ-025 SHALL, for a write, write the received byte to reg[pointer] one cycle after the 8th rise, and pulse wr_valid with wr_addr/wr_data.
REQ-026 SHALL, for a write, load the status byte into TX for the next byte.
REQ-027 SHALL, with burst = 1, increment the pointer after every data byte, wrapping from NUM_REGS-1 to 0x00.
REQ-028 SHALL, with burst = 0, process only one data byte; later bytes are ignored, with miso 0 and no writes.
REQ-029 SHALL return 0x00 on reads of pointer >= NUM_REGS and discard writes to those addresses without pulsing wr_valid.
REQ-030 SHALL, when cs_n rises mid-byte, discard the partial byte with no write and no strobe, deassert miso_oe, and enter IDLE.
REQ-031 SHALL treat cs_n falling in the same cycle as an sclk edge as cs_n first; that sclk edge is ignored.
REQ-032 SHALL hold the register file contents across transactions.

Reset
REQ-033 SHALL, on rst, clear asynchronously: state = IDLE; miso = 0, miso_oe = 0, wr_valid = 0, strobe_valid = 0; wr_addr, wr_data and strobe_addr = 0; bit and byte counters, TX and RX = 0; register file = 0x00; synchronizers preset to sclk = 0, mosi = 0, cs_n = 1.
REQ-034 SHALL, when rst is asserted mid-transaction, abort the transaction; after rst releases, wait for a fresh cs_n falling edge.

Structure
REQ-035 SHALL put the header bit positions, STROBE_BASE = 6'h30, the FSM state enum and the status-byte layout in package cc1200_spi_pkg.
REQ-036 SHALL use one sub-module, cc1200_sync_edge: a parameterized synchronizer plus rise/fall detector, instantiated per input.

Verification
REQ-037 Write then read: master 0x05 (single write, addr 5), 0xA5; then 0x85, 0x00 -> wr_valid once with addr 5/data 0xA5; read returns MISO 0x00 then 0xA5.
REQ-038 Burst wrap: 0x6E (burst write, addr 0x2E), 0x11 0x22 0x33 -> writes to 0x2E, 0x2F, 0x00; burst read 0xEE returns 0x11 0x22 0x33.
REQ-039 Strobe: chip_state = 3'b010, master sends 0x36 -> MISO 0x20, strobe_valid pulses once with strobe_addr 0x36, no wr_valid.
REQ-040 Abort: cs_n rises after 5 bits of a write data byte -> no wr_valid, miso_oe = 0 within SYNC_STAGES+2 cycles, register unchanged.
REQ-041 Reset mid-burst: rst asserted during the 2nd data byte -> all outputs 0, registers 0x00; the next transaction decodes correctly.
REQ-042 Clock ratio: clk = 8x SCLK with CS_n-to-first-SCLK = 4 clk cycles -> no bit errors over 256 random burst transactions.
